// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the CPU data-memory bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmb_state_e;

  localparam int unsigned DMB_TIMEOUT_CYC = 256;
  localparam logic [3:0]  DMB_WEB_READ    = 4'hF;

  function automatic logic [31:0] dmb_word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// CPU-side and memory-side signals of the data-memory bridge.
interface dmem_bridge_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_web;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  // The bridge itself.
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_web,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output cpu_rdata, cpu_stall,
    output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output bus_err
  );

  // The CPU and memory surrounding the bridge.
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_web,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  bus_err
  );
endinterface

// File: rtl/dmb_timeout_cnt.sv
// WAIT-state cycle counter; expired is high on the last permitted WAIT cycle.
module dmb_timeout_cnt
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DMB_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign expired   = w_expired;

  // Saturates at the limit so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en && !w_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle CPU data port onto a valid/ready memory bus,
// stalling the CPU until the access completes or times out.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DMB_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rst,
  dmem_bridge_if.slave  bus
);

  dmb_state_e  r_state;
  dmb_state_e  w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_web;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic        w_latch;
  logic        w_capture;
  logic        w_timeout;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_expired;
  logic        w_is_read;
  logic [31:0] w_cap_data;

  assign w_is_read  = (r_web == DMB_WEB_READ);
  assign w_cap_data = w_is_read ? bus.mem_rdata : 32'h0;
  assign w_cnt_en   = (r_state == ST_WAIT);

  dmb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_cnt_clr),
    .en      (w_cnt_en),
    .expired (w_expired)
  );

  // A response coinciding with the timeout takes priority over the abort.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          if (bus.mem_resp_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_web     <= 4'h0;
      r_rdata   <= 32'h0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr  <= dmb_word_addr(bus.cpu_addr);
        r_wdata <= bus.cpu_wdata;
        r_web   <= bus.cpu_web;
      end
      if (w_capture) begin
        r_rdata <= w_cap_data;
      end else if (w_timeout) begin
        r_rdata   <= 32'h0;
        r_bus_err <= 1'b1;
      end
    end
  end

  assign bus.cpu_stall     = bus.cpu_req && (r_state != ST_DONE);
  assign bus.cpu_rdata     = r_rdata;
  assign bus.mem_req_valid = (r_state == ST_REQ);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_we        = !w_is_read;
  assign bus.mem_wstrb     = ~r_web;
  assign bus.mem_wdata     = r_wdata;
  assign bus.bus_err       = r_bus_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: transaction-level model plus directed scenarios.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  dmem_bridge_if bus ();

  dmem_bridge #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding access, its phase and wait count.
  bit          m_live = 1'b0;
  bit          m_busy, m_sent, m_done, m_err;
  int          m_wcnt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_web;

  task automatic model_complete(input logic [31:0] data);
    m_rdata = (m_web == 4'hF) ? data : 32'h0;
    m_busy  = 1'b0;
    m_done  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk1("cpu_stall", bus.cpu_stall, bus.cpu_req && !m_done);
      chk1("mem_req_valid", bus.mem_req_valid, m_busy && !m_sent);
      chk("cpu_rdata", bus.cpu_rdata, m_rdata);
      chk1("bus_err", bus.bus_err, m_err);
      if (m_busy) begin
        chk("mem_addr", bus.mem_addr, m_addr & 32'hFFFF_FFFC);
        chk1("mem_we", bus.mem_we, m_web != 4'hF);
        chk("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, ~m_web});
        chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
    if (rst) begin
      m_live = 1'b1; m_busy = 1'b0; m_sent = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_wcnt = 0; m_rdata = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_web = 4'h0;
    end else if (m_live) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (bus.cpu_req) begin
          m_busy = 1'b1; m_sent = 1'b0;
          m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata; m_web = bus.cpu_web;
        end
      end else if (!m_sent) begin
        if (bus.mem_req_ready) begin
          if (bus.mem_resp_valid) model_complete(bus.mem_rdata);
          else begin m_sent = 1'b1; m_wcnt = 0; end
        end
      end else if (bus.mem_resp_valid) begin
        model_complete(bus.mem_rdata);
      end else if (m_wcnt == TO - 1) begin
        m_err = 1'b1; m_rdata = 32'h0; m_busy = 1'b0; m_done = 1'b1;
      end else begin
        m_wcnt++;
      end
    end
  end

  // One CPU access against a memory that raises ready after rdy_dly REQ cycles
  // and answers resp_dly cycles after acceptance (0 = same cycle, <0 = never).
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] web, input int rdy_dly, input int resp_dly,
                           input logic [31:0] rd, output int stalls,
                           output logic [31:0] fin_rdata, output logic fin_err,
                           output logic [31:0] seen_addr, output logic seen_we,
                           output logic [3:0] seen_wstrb, output logic wd_stable);
    int vcnt = 0;
    int wcnt = 0;
    bit acc = 1'b0;
    bit fin = 1'b0;
    stalls = 0; fin_rdata = 32'hX; fin_err = 1'bX;
    seen_addr = 32'hX; seen_we = 1'bX; seen_wstrb = 4'hX; wd_stable = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_web = web;
    bus.mem_rdata = rd;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      bus.mem_req_ready  = bus.mem_req_valid && (vcnt >= rdy_dly);
      bus.mem_resp_valid = (bus.mem_req_ready && resp_dly == 0) ||
                           (acc && resp_dly > 0 && wcnt == resp_dly);
      @(negedge clk);
      if (bus.cpu_stall) stalls++;
      else begin fin = 1'b1; fin_rdata = bus.cpu_rdata; fin_err = bus.bus_err; end
      if (bus.mem_req_valid) begin
        vcnt++;
        seen_addr = bus.mem_addr; seen_we = bus.mem_we; seen_wstrb = bus.mem_wstrb;
        if (bus.mem_wdata !== wdata) wd_stable = 1'b0;
        if (bus.mem_req_ready) acc = 1'b1;
      end
      if (acc) wcnt++;
      @(posedge clk); #1;
    end
    chk1("access_completed", fin, 1'b1);
    bus.cpu_req = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_random(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      if (!bus.cpu_stall) begin
        bus.cpu_req   = 1'($urandom % 2);
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
        bus.cpu_web   = ($urandom % 2 == 0) ? 4'hF : 4'($urandom);
      end
      bus.mem_req_ready  = 1'($urandom % 2);
      bus.mem_resp_valid = ($urandom % 100) < pct;
      bus.mem_rdata      = $urandom;
      rst                = ($urandom % 300) == 0;
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.cpu_req = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
  endtask

  int          st;
  logic [31:0] frd, sa;
  logic        ferr, swe, wds;
  logic [3:0]  sws;
  bit   [7:0]  v_pat, s_pat;
  bit          acc_b;

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0; bus.cpu_web = 4'hF;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_stall", bus.cpu_stall, 1'b0);
    chk1("rst_valid", bus.mem_req_valid, 1'b0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk1("rst_bus_err", bus.bus_err, 1'b0);
    @(posedge clk); #1;

    // Load, zero-wait memory
    do_access(32'h0000_1006, 32'h0, 4'hF, 0, 1, 32'hDEAD_BEEF, st, frd, ferr, sa, swe, sws, wds);
    chk("load_stalls", st, 3);
    chk("load_rdata", frd, 32'hDEAD_BEEF);
    chk("load_addr", sa, 32'h0000_1004);
    chk1("load_we", swe, 1'b0);

    // Store with ready held low for 5 REQ cycles
    do_access(32'h0000_2002, 32'h0000_ABCD, 4'b1100, 5, 1, 32'h1111_2222, st, frd, ferr, sa, swe, sws, wds);
    chk("store_stalls", st, 8);
    chk1("store_we", swe, 1'b1);
    chk("store_wstrb", {28'h0, sws}, 32'h3);
    chk1("store_wdata_stable", wds, 1'b1);
    chk("store_rdata", frd, 32'h0);

    // Ready and response in the same REQ cycle
    do_access(32'h0000_3000, 32'h0, 4'hF, 0, 0, 32'h1234_5678, st, frd, ferr, sa, swe, sws, wds);
    chk("samecyc_stalls", st, 2);
    chk("samecyc_rdata", frd, 32'h1234_5678);

    // Back-to-back with cpu_req held through DONE
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_web = 4'hF;
    bus.mem_req_ready = 1'b1; bus.mem_rdata = 32'h0BAD_F00D; acc_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.mem_resp_valid = acc_b;
      @(negedge clk);
      v_pat[c] = bus.mem_req_valid;
      s_pat[c] = bus.cpu_stall;
      acc_b = bus.mem_req_valid && bus.mem_req_ready;
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    chk("b2b_valid_pattern", {24'h0, v_pat}, 32'h22);
    chk("b2b_stall_pattern", {24'h0, s_pat}, 32'h77);

    // Timeout, then error persists through a good access
    do_access(32'h0000_5000, 32'h0, 4'hF, 0, -1, 32'h7777_7777, st, frd, ferr, sa, swe, sws, wds);
    chk("timeout_stalls", st, 2 + TO);
    chk1("timeout_err", ferr, 1'b1);
    chk("timeout_rdata", frd, 32'h0);
    do_access(32'h0000_5004, 32'h0, 4'hF, 0, 1, 32'h5555_AAAA, st, frd, ferr, sa, swe, sws, wds);
    chk1("err_sticky", ferr, 1'b1);
    chk("after_err_rdata", frd, 32'h5555_AAAA);

    // Response on the very cycle the timeout would fire
    pulse_rst();
    do_access(32'h0000_6000, 32'h0, 4'hF, 0, TO, 32'hCAFE_0001, st, frd, ferr, sa, swe, sws, wds);
    chk("edge_stalls", st, 2 + TO);
    chk1("edge_err", ferr, 1'b0);
    chk("edge_rdata", frd, 32'hCAFE_0001);

    // Reset during WAIT, then a late response
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_web = 4'hF; bus.mem_req_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.cpu_req = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk1("rstmid_stall", bus.cpu_stall, 1'b0);
    chk1("rstmid_valid", bus.mem_req_valid, 1'b0);
    chk("rstmid_rdata", bus.cpu_rdata, 32'h0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_rdata_after", bus.cpu_rdata, 32'h0);
    @(posedge clk); #1;

    run_random(2000, 40);
    run_random(2000, 3);
    repeat (TO + 5) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
